// File: rtl/mem_responder_if.sv
// Word-wide memory port between a cache (master) and a memory responder (slave).
interface mem_responder_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int WORD_WIDTH = 64
) ();
    logic [ADDR_WIDTH-1:0] maddr;
    logic [WORD_WIDTH-1:0] mout;
    logic [WORD_WIDTH-1:0] min;
    logic                  mre;
    logic                  mwe;
    logic                  mready;

    modport master (output maddr, output mout, output mre, output mwe,
                    input  min,   input  mready);
    modport slave  (input  maddr, input  mout, input  mre, input  mwe,
                    output min,   output mready);
endinterface

// File: rtl/mem_responder.sv
// Main-memory model: word-addressed store answering one request at a time with
// DRAM-like open-row latency, plus read/write/row-hit statistics and a sticky error flag.
module mem_responder #(
    parameter int ADDR_WIDTH   = 64,
    parameter int WORD_WIDTH   = 64,
    parameter int SIZE_BITS    = 10,
    parameter int ROW_BITS     = 4,
    parameter int HIT_LATENCY  = 2,
    parameter int MISS_LATENCY = 6,
    parameter int COUNT_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    mem_responder_if.slave         bus,
    output logic [COUNT_WIDTH-1:0] read_count,
    output logic [COUNT_WIDTH-1:0] write_count,
    output logic [COUNT_WIDTH-1:0] row_hits,
    output logic                   error
);
    localparam int DEPTH = 1 << SIZE_BITS;
    localparam int RW    = SIZE_BITS - ROW_BITS;
    localparam int CW    = $clog2(MISS_LATENCY + 1);

    typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_e;

    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [SIZE_BITS-1:0]   index_q, index_d;
    logic                   write_q, write_d;
    logic [WORD_WIDTH-1:0]  wdata_q, wdata_d;
    logic [WORD_WIDTH-1:0]  min_q, min_d;
    logic                   mready_q, mready_d;
    logic [COUNT_WIDTH-1:0] read_count_q, read_count_d;
    logic [COUNT_WIDTH-1:0] write_count_q, write_count_d;
    logic [COUNT_WIDTH-1:0] row_hits_q, row_hits_d;
    logic                   error_q, error_d;
    logic                   row_valid_q, row_valid_d;
    logic [RW-1:0]          open_row_q, open_row_d;

    logic [WORD_WIDTH-1:0]  store_mem [DEPTH];

    logic                   req_s;
    logic                   hit_s;
    logic                   high_bits_s;
    logic                   commit_wr_s;
    logic [SIZE_BITS-1:0]   req_index_s;

    // Request decode and open-row classification.
    always_comb begin
        req_s       = bus.mre | bus.mwe;
        req_index_s = bus.maddr[SIZE_BITS-1:0];
        hit_s       = row_valid_q & (req_index_s[SIZE_BITS-1:ROW_BITS] == open_row_q);
        high_bits_s = (bus.maddr >> SIZE_BITS) != '0;
        commit_wr_s = (state_q == BUSY) & (cnt_q == '0) & write_q;
    end

    // Next-state and output logic for the IDLE/BUSY controller.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        index_d       = index_q;
        write_d       = write_q;
        wdata_d       = wdata_q;
        min_d         = min_q;
        mready_d      = mready_q;
        read_count_d  = read_count_q;
        write_count_d = write_count_q;
        row_hits_d    = row_hits_q;
        error_d       = error_q;
        row_valid_d   = row_valid_q;
        open_row_d    = open_row_q;
        case (state_q)
            IDLE: begin
                if (req_s) begin
                    state_d     = BUSY;
                    mready_d    = 1'b0;
                    index_d     = req_index_s;
                    write_d     = bus.mwe;
                    wdata_d     = bus.mout;
                    cnt_d       = hit_s ? CW'(HIT_LATENCY - 1) : CW'(MISS_LATENCY - 1);
                    row_valid_d = 1'b1;
                    open_row_d  = req_index_s[SIZE_BITS-1:ROW_BITS];
                    if (bus.mwe) begin
                        write_count_d = write_count_q + COUNT_WIDTH'(1);
                    end else begin
                        read_count_d = read_count_q + COUNT_WIDTH'(1);
                    end
                    if (hit_s) begin
                        row_hits_d = row_hits_q + COUNT_WIDTH'(1);
                    end else begin
                        row_hits_d = row_hits_q;
                    end
                    // A simultaneous read+write resolves as a write but is still a protocol error.
                    error_d = error_q | (bus.mre & bus.mwe) | high_bits_s;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                error_d = error_q | req_s;
                if (cnt_q == '0) begin
                    state_d  = IDLE;
                    mready_d = 1'b1;
                    if (!write_q) begin
                        min_d = store_mem[index_q];
                    end else begin
                        min_d = min_q;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d  = IDLE;
                mready_d = 1'b1;
            end
        endcase
    end

    // Controller, datapath and statistics registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            index_q       <= '0;
            write_q       <= 1'b0;
            wdata_q       <= '0;
            min_q         <= '0;
            mready_q      <= 1'b1;
            read_count_q  <= '0;
            write_count_q <= '0;
            row_hits_q    <= '0;
            error_q       <= 1'b0;
            row_valid_q   <= 1'b0;
            open_row_q    <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            index_q       <= index_d;
            write_q       <= write_d;
            wdata_q       <= wdata_d;
            min_q         <= min_d;
            mready_q      <= mready_d;
            read_count_q  <= read_count_d;
            write_count_q <= write_count_d;
            row_hits_q    <= row_hits_d;
            error_q       <= error_d;
            row_valid_q   <= row_valid_d;
            open_row_q    <= open_row_d;
        end
    end

    // Backing store is never reset; an abandoned access never reaches commit since reset forces IDLE.
    always_ff @(posedge clk) begin
        if (commit_wr_s) begin
            store_mem[index_q] <= wdata_q;
        end
    end

    assign bus.min     = min_q;
    assign bus.mready  = mready_q;
    assign read_count  = read_count_q;
    assign write_count = write_count_q;
    assign row_hits    = row_hits_q;
    assign error       = error_q;
endmodule

// File: tb/tb_mem_responder.sv
// Randomised bench for mem_responder: event-level reference model with busy-until
// deadlines checked every cycle, plus directed scenarios with literal expectations.
module tb_mem_responder;
    localparam int DEPTH     = 1024;
    localparam int ROW_WORDS = 16;
    localparam int HIT_L     = 2;
    localparam int MISS_L    = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] read_count, write_count, row_hits;
    logic        error;

    mem_responder_if #(.ADDR_WIDTH(64), .WORD_WIDTH(64)) bus ();

    mem_responder dut (
        .clk(clk), .rst(rst), .bus(bus),
        .read_count(read_count), .write_count(write_count),
        .row_hits(row_hits), .error(error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an accepted request is due at a fixed future cycle number.
    logic [63:0] mem_m [DEPTH];
    bit          busy_m   = 1'b0;
    longint      cyc_m    = 0;
    longint      done_m   = 0;
    bit          op_wr_m  = 1'b0;
    int          idx_m    = 0;
    logic [63:0] wd_m     = '0;
    logic [63:0] min_m    = '0;
    int unsigned rc_m = 0, wc_m = 0, rh_m = 0;
    bit          err_m    = 1'b0;
    bit          row_v_m  = 1'b0;
    int          row_m    = 0;
    bit          hit_m;
    int          new_idx_m;

    initial for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_m = 1'b0; min_m = '0; rc_m = 0; wc_m = 0; rh_m = 0;
            err_m = 1'b0; row_v_m = 1'b0;
        end else begin
            cyc_m++;
            if (busy_m) begin
                if (bus.mre || bus.mwe) err_m = 1'b1;
                if (cyc_m == done_m) begin
                    if (op_wr_m) mem_m[idx_m] = wd_m;
                    else         min_m = mem_m[idx_m];
                    busy_m = 1'b0;
                end
            end else if (bus.mre || bus.mwe) begin
                new_idx_m = int'(bus.maddr % 64'(DEPTH));
                hit_m  = row_v_m && (new_idx_m / ROW_WORDS == row_m);
                idx_m  = new_idx_m;
                done_m = cyc_m + (hit_m ? HIT_L : MISS_L);
                busy_m = 1'b1;
                op_wr_m = bus.mwe;
                wd_m   = bus.mout;
                if (bus.mwe) wc_m++; else rc_m++;
                if (hit_m) rh_m++;
                if (bus.mre && bus.mwe) err_m = 1'b1;
                if (bus.maddr >= 64'(DEPTH)) err_m = 1'b1;
                row_v_m = 1'b1;
                row_m   = new_idx_m / ROW_WORDS;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        check("mready", bus.mready, !busy_m);
        check("min", bus.min, min_m);
        check("read_count", read_count, rc_m);
        check("write_count", write_count, wc_m);
        check("row_hits", row_hits, rh_m);
        check("error", error, err_m);
    end

    task automatic wait_idle(output int lat);
        lat = 0;
        while (!bus.mready && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!bus.mready) check("idle_timeout", bus.mready, 1'b1);
    endtask

    // Issue a one-cycle request and return the number of busy cycles observed.
    task automatic req(input logic re, input logic we, input logic [63:0] a,
                       input logic [63:0] d, output int lat);
        bus.mre = re; bus.mwe = we; bus.maddr = a; bus.mout = d;
        @(posedge clk); #1;
        bus.mre = 1'b0; bus.mwe = 1'b0;
        wait_idle(lat);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
    endtask

    int lat;
    logic [63:0] a;

    initial begin
        bus.mre = 1'b0; bus.mwe = 1'b0; bus.maddr = '0; bus.mout = '0;
        #1 rst = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        // The low words used below start from zero.
        for (int i = 0; i < 64; i++) req(1'b0, 1'b1, 64'(i), 64'h0, lat);
        do_reset();
        check("reset_mready", bus.mready, 1'b1);
        check("reset_counts", {read_count, write_count}, 64'h0);

        // Write then read in the same row.
        req(1'b0, 1'b1, 64'h5, 64'hDEAD, lat);
        check("wr_miss_latency", 64'(lat), 64'd6);
        req(1'b1, 1'b0, 64'h5, 64'h0, lat);
        check("rd_hit_latency", 64'(lat), 64'd2);
        check("rd_data", bus.min, 64'hDEAD);
        check("row_hits_1", row_hits, 64'd1);
        check("rc_1", read_count, 64'd1);
        check("wc_1", write_count, 64'd1);

        // Row change.
        req(1'b1, 1'b0, 64'h5, 64'h0, lat);
        req(1'b1, 1'b0, 64'h25, 64'h0, lat);
        check("row_change_latency", 64'(lat), 64'd6);
        check("row_hits_2", row_hits, 64'd2);
        req(1'b1, 1'b0, 64'h26, 64'h0, lat);
        check("same_row_latency", 64'(lat), 64'd2);

        // Request while busy is ignored.
        do_reset();
        bus.mre = 1'b1; bus.maddr = 64'h1;
        @(posedge clk); #1;
        bus.mre = 1'b0;
        @(posedge clk); #1;
        bus.mwe = 1'b1; bus.maddr = 64'h2; bus.mout = 64'h99;
        @(posedge clk); #1;
        bus.mwe = 1'b0;
        wait_idle(lat);
        check("busy_wc", write_count, 64'd0);
        check("busy_error", error, 1'b1);
        req(1'b1, 1'b0, 64'h2, 64'h0, lat);
        check("busy_store", bus.min, 64'h0);

        // Simultaneous read and write.
        do_reset();
        req(1'b1, 1'b0, 64'h5, 64'h0, lat);
        req(1'b1, 1'b1, 64'h3, 64'h77, lat);
        check("both_wc", write_count, 64'd1);
        check("both_rc", read_count, 64'd1);
        check("both_error", error, 1'b1);
        check("both_min", bus.min, 64'hDEAD);
        req(1'b1, 1'b0, 64'h3, 64'h0, lat);
        check("both_written", bus.min, 64'h77);

        // Reset in the middle of an access.
        do_reset();
        bus.mwe = 1'b1; bus.maddr = 64'h9; bus.mout = 64'h55;
        @(posedge clk); #1;
        bus.mwe = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("midrst_mready", bus.mready, 1'b1);
        check("midrst_min", bus.min, 64'h0);
        check("midrst_wc", write_count, 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        req(1'b1, 1'b0, 64'h9, 64'h0, lat);
        check("midrst_store", bus.min, 64'h0);

        // Aliasing of high address bits.
        do_reset();
        req(1'b0, 1'b1, 64'h405, 64'hAB, lat);
        req(1'b1, 1'b0, 64'h5, 64'h0, lat);
        check("alias_data", bus.min, 64'hAB);
        check("alias_error", error, 1'b1);

        // Random traffic, including busy-time requests and occasional resets.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 499) == 0) begin
                bus.mre = 1'b0; bus.mwe = 1'b0;
                do_reset();
            end
            a = 64'($urandom_range(0, 63));
            if ($urandom_range(0, 15) == 0) a = a | (64'd1 << $urandom_range(10, 63));
            bus.maddr = a;
            bus.mout  = {$urandom, $urandom};
            bus.mre   = ($urandom_range(0, 5) == 0);
            bus.mwe   = ($urandom_range(0, 5) == 0);
            @(posedge clk); #1;
        end
        bus.mre = 1'b0; bus.mwe = 1'b0;
        wait_idle(lat);
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the cache's word-wide memory port (maddr/mout/min/mre/mwe/mready); it is the other end of that port.
- Holds a word-addressed backing store and answers one request at a time with a configurable, open-row-dependent latency.
- Gives the simulator a main-memory model with DRAM-like row-buffer timing, plus access statistics.

Parameters:
ADDR_WIDTH, 64, width of maddr in bits (word address)
WORD_WIDTH, 64, data word width in bits
SIZE_BITS, 10, backing store holds 2^SIZE_BITS words
ROW_BITS, 4, 2^ROW_BITS words per DRAM row (open-row granularity)
HIT_LATENCY, 2, busy cycles for an access to the open row (must be >= 1)
MISS_LATENCY, 6, busy cycles for an access to a different or no open row (must be >= HIT_LATENCY)
COUNT_WIDTH, 32, width of statistics counters

Ports:
clk  in  1  clock, all state changes on rising edge
rst  in  1  asynchronous, active-low reset
maddr  in  ADDR_WIDTH  request word address
mout  in  WORD_WIDTH  write data from initiator
min  out  WORD_WIDTH  read data to initiator
mre  in  1  read request, one-cycle pulse
mwe  in  1  write request, one-cycle pulse
mready  out  1  high = idle, able to accept; low = busy
read_count  out  COUNT_WIDTH  accepted reads
write_count  out  COUNT_WIDTH  accepted writes
row_hits  out  COUNT_WIDTH  accepted requests that hit the open row
error  out  1  sticky protocol or range error flag

Behaviour:
- Reset (rst low, asynchronous): state IDLE, mready=1, min=0, all counters 0, error=0, open row invalid. Backing store is not reset; it is initialised to zero at simulation start.
- States: IDLE, BUSY.
- IDLE: mready=1. At a clock edge with mre or mwe high, the request is accepted:
  - latch the index maddr[SIZE_BITS-1:0], the opcode and mout;
  - classify hit as (open row valid and maddr[SIZE_BITS-1:ROW_BITS] == open row);
  - load the busy counter with HIT_LATENCY-1 on a hit, MISS_LATENCY-1 otherwise;
  - go to BUSY, increment read_count or write_count, and increment row_hits on a hit;
  - make the open row equal to the accessed row and mark it valid.
- BUSY: mready=0. The counter decrements each cycle. When it is 0 at a clock edge, the access is performed:
  - read: min <= store[index];
  - write: store[index] <= latched mout.
  - The block then returns to IDLE.
- Latency: if the request is accepted at edge k with latency L, mready is low for exactly L cycles and high again after edge k+L. For reads, min is valid in that same cycle.
- min holds the last read result until the next read completes; writes never change min.
- Both mre and mwe high at acceptance: the write is performed, only write_count increments, error is set.
- mre or mwe high while BUSY: ignored (no state or counter change), error is set.
- Address bits above SIZE_BITS-1 are nonzero at acceptance: the access still uses the low SIZE_BITS bits (aliasing), error is set.
- A read that follows a write to the same address returns the new data; this holds because each access commits before the block returns to IDLE.
- Counters wrap modulo 2^COUNT_WIDTH without saturation.
- error clears only on reset.
- Reset asserted mid-BUSY: the in-flight access is abandoned. It is not committed, the store is unchanged, min=0, and mready=1 immediately.

Test Plan:
- Write then read, same row: after reset, pulse mwe with maddr=0x5, mout=0xDEAD → mready low 6 cycles (miss). Then pulse mre with maddr=0x5 → mready low 2 cycles (hit), min=0xDEAD when mready rises, row_hits=1, read_count=1, write_count=1.
- Row change: read 0x5 then read 0x25 with ROW_BITS=4 → second access busy 6 cycles, row_hits unchanged. A third read of 0x26 → busy 2 cycles.
- Busy-time request: pulse mre at 0x1, then pulse mwe at 0x2 two cycles later while mready=0 → second request ignored, write_count=0, error=1, store[0x2] unchanged.
- Simultaneous mre and mwe at 0x3 with mout=0x77 → write performed, write_count=1, read_count=0, error=1, min unchanged.
- Reset mid-access: pulse mwe at 0x9 with mout=0x55, drive rst low 3 cycles later → mready=1 and min=0 immediately, counters 0. A subsequent read of 0x9 returns 0.
- Aliasing: with SIZE_BITS=10, write 0xAB to maddr=0x405, then read maddr=0x5 → min=0xAB, error=1.
